// File: rtl/cordic_hyp_scheduler_pkg.sv
// Shared constants for the hyperbolic CORDIC scheduler.
//   DEF_W        default operand/result width (Q1.14 signed)
//   DEF_ENG_LAT  default engine latency, start cycle to result-valid cycle
//   ID_W         width of the requester tag on results
//   Z_MAX        hyperbolic CORDIC convergence limit (~1.118 in Q1.14)
//   ST_*         FSM state encodings
package cordic_hyp_scheduler_pkg;

  localparam int unsigned DEF_W       = 16;
  localparam int unsigned DEF_ENG_LAT = 17;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned ST_W        = 3;

  localparam logic [15:0] Z_MAX = 16'h478D;

  localparam logic [ST_W-1:0] ST_DRAIN = 3'd0;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd1;
  localparam logic [ST_W-1:0] ST_ISSUE = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [ST_W-1:0] ST_RESP  = 3'd4;

  // True when |z| lies outside the convergence range; 0x8000 maps to 32768.
  function automatic logic z_exceeds_max(input logic [15:0] z);
    logic [15:0] mag;
    mag = z[15] ? 16'(-z) : z;
    return (mag > Z_MAX);
  endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the priority pointer, wrapping around.
//   i_req      N-bit request vector
//   i_ptr      index holding highest priority this cycle
//   o_grant_c  one-hot grant
//   o_idx_c    index of the granted request
//   o_any_c    at least one request asserted
module cordic_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % N);
      if (!o_any_c && i_req[w_cand]) begin
        o_any_c           = 1'b1;
        o_idx_c           = w_cand;
        o_grant_c[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_hyp_scheduler.sv
// Shares one iterative sinh/cosh CORDIC engine among N requesters with
// round-robin arbitration and fixed-latency result capture.
// Optional feature macro: CORDIC_SCHED_RANGE_CHK_EN (adds o_rsp_err and
// short-circuits operands outside the convergence range).
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req_valid/i_req_z    per-requester valid and operand (slice i*W +: W)
//   o_req_ready            one-hot accept pulse, same cycle as the grant
//   o_rsp_valid/id/sinh/cosh  tagged result pulse; payload holds afterwards
//   o_rsp_err              (macro only) operand rejected, results forced to 0
//   o_eng_st/o_eng_z0      engine start pulse and operand
//   i_eng_sinh/i_eng_cosh  engine results, valid ENG_LAT cycles after start
module cordic_hyp_scheduler
  import cordic_hyp_scheduler_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned ENG_LAT = DEF_ENG_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N-1:0]      i_req_valid,
  input  logic [N*W-1:0]    i_req_z,
  output logic [N-1:0]      o_req_ready,
  output logic              o_rsp_valid,
  output logic [ID_W-1:0]   o_rsp_id,
  output logic [W-1:0]      o_rsp_sinh,
  output logic [W-1:0]      o_rsp_cosh,
`ifdef CORDIC_SCHED_RANGE_CHK_EN
  output logic              o_rsp_err,
`endif
  output logic              o_eng_st,
  output logic [W-1:0]      o_eng_z0,
  input  logic [W-1:0]      i_eng_sinh,
  input  logic [W-1:0]      i_eng_cosh
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(ENG_LAT + 3);

  logic [ST_W-1:0]  r_state,    w_state_n;
  // Shared counter: drain countdown in DRAIN, engine latency count in WAIT.
  logic [CNT_W-1:0] r_cnt,      w_cnt_n;
  logic [IDX_W-1:0] r_rr_ptr,   w_rr_ptr_n;
  logic [ID_W-1:0]  r_id,       w_id_n;
  logic [W-1:0]     r_eng_z0,   w_eng_z0_n;
  logic             r_eng_st,   w_eng_st_n;
  logic             r_rsp_valid, w_rsp_valid_n;
  logic [ID_W-1:0]  r_rsp_id,   w_rsp_id_n;
  logic [W-1:0]     r_rsp_sinh, w_rsp_sinh_n;
  logic [W-1:0]     r_rsp_cosh, w_rsp_cosh_n;
`ifdef CORDIC_SCHED_RANGE_CHK_EN
  logic             r_rsp_err,  w_rsp_err_n;
`endif

  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic [W-1:0]     w_gnt_z;

  cordic_rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  assign w_gnt_z = i_req_z[32'(w_idx)*W +: W];

  // Next-state, next-register and accept-pulse logic.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_rr_ptr_n    = r_rr_ptr;
    w_id_n        = r_id;
    w_eng_z0_n    = r_eng_z0;
    w_eng_st_n    = 1'b0;
    w_rsp_valid_n = 1'b0;
    w_rsp_id_n    = r_rsp_id;
    w_rsp_sinh_n  = r_rsp_sinh;
    w_rsp_cosh_n  = r_rsp_cosh;
`ifdef CORDIC_SCHED_RANGE_CHK_EN
    w_rsp_err_n   = r_rsp_err;
`endif
    o_req_ready   = '0;
    case (r_state)
      ST_DRAIN: begin
        // Engine has no reset; let any in-flight op run out before issuing.
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_n   = '0;
          w_state_n = ST_IDLE;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_any && !i_rst) begin
          o_req_ready = w_grant;
          w_rr_ptr_n  = (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + IDX_W'(1);
          w_id_n      = ID_W'(w_idx);
          w_eng_z0_n  = w_gnt_z;
`ifdef CORDIC_SCHED_RANGE_CHK_EN
          if (z_exceeds_max(16'(w_gnt_z))) begin
            w_state_n     = ST_RESP;
            w_rsp_valid_n = 1'b1;
            w_rsp_id_n    = ID_W'(w_idx);
            w_rsp_sinh_n  = '0;
            w_rsp_cosh_n  = '0;
            w_rsp_err_n   = 1'b1;
          end else begin
            w_state_n  = ST_ISSUE;
            w_eng_st_n = 1'b1;
          end
`else
          w_state_n  = ST_ISSUE;
          w_eng_st_n = 1'b1;
`endif
        end
      end
      ST_ISSUE: begin
        w_cnt_n   = CNT_W'(1);
        w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // Engine outputs are only meaningful on this one cycle.
        if (r_cnt == CNT_W'(ENG_LAT)) begin
          w_rsp_valid_n = 1'b1;
          w_rsp_id_n    = r_id;
          w_rsp_sinh_n  = i_eng_sinh;
          w_rsp_cosh_n  = i_eng_cosh;
`ifdef CORDIC_SCHED_RANGE_CHK_EN
          w_rsp_err_n   = 1'b0;
`endif
          w_state_n     = ST_RESP;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_DRAIN;
        w_cnt_n   = CNT_W'(ENG_LAT + 2);
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_DRAIN;
      r_cnt       <= CNT_W'(ENG_LAT + 2);
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_eng_z0    <= '0;
      r_eng_st    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sinh  <= '0;
      r_rsp_cosh  <= '0;
`ifdef CORDIC_SCHED_RANGE_CHK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_rr_ptr    <= w_rr_ptr_n;
      r_id        <= w_id_n;
      r_eng_z0    <= w_eng_z0_n;
      r_eng_st    <= w_eng_st_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_id    <= w_rsp_id_n;
      r_rsp_sinh  <= w_rsp_sinh_n;
      r_rsp_cosh  <= w_rsp_cosh_n;
`ifdef CORDIC_SCHED_RANGE_CHK_EN
      r_rsp_err   <= w_rsp_err_n;
`endif
    end
  end

  assign o_eng_st    = r_eng_st;
  assign o_eng_z0    = r_eng_z0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sinh  = r_rsp_sinh;
  assign o_rsp_cosh  = r_rsp_cosh;
`ifdef CORDIC_SCHED_RANGE_CHK_EN
  assign o_rsp_err   = r_rsp_err;
`endif

endmodule
